div_unit: RTL and testbench
===========================

# div_unit

Sequential signed 32-bit divider for the multicycle MIPS core. It sits beside the ALU and directly upstream of the HI/LO register pair. The control unit issues `start` with register A as dividend and register B as divisor. After a fixed latency the block delivers the quotient for LO and the remainder for HI, signalling completion with `done`, or raising `div_zero` so the control unit can take the divide-by-zero exception path.

## Interface
- `WIDTH`, 32: operand width; only 32 is required to be supported.
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request; sampled only in IDLE.
- `dividend`, in, 32: signed dividend (register A); sampled on the start edge only.
- `divisor`, in, 32: signed divisor (register B); sampled on the start edge only.
- `busy`, out, 1: high while a division is in progress (CALC or FIX).
- `done`, out, 1: one-cycle completion pulse; `hi_out`/`lo_out` are valid from this cycle.
- `div_zero`, out, 1: one-cycle pulse when the sampled divisor is 0.
- `hi_out`, out, 32: remainder of the last successful division.
- `lo_out`, out, 32: quotient of the last successful division.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE, `start`=1, divisor==0:**
  - `div_zero` is set for the next cycle.
  - State stays IDLE.
  - `hi_out`/`lo_out` are unchanged and `done` stays 0.
- **IDLE, `start`=1, divisor!=0:**
  - Latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31].
  - Latch the magnitudes |dividend| and |divisor| as 32-bit unsigned values (|0x80000000| = 0x80000000).
  - Clear the 33-bit partial remainder and the 6-bit counter. Go to CALC.
- **CALC, one restoring step per cycle:**
  - Shift {rem, quo} left by 1, bringing the next dividend bit (MSB first) into rem[0].
  - trial = rem − |divisor|, computed at 33 bits.
  - If trial is non-negative: rem = trial and quo[0] = 1. Otherwise quo[0] = 0.
  - Increment the counter. After the 32nd step, go to FIX.
- **FIX:**
  - lo_out = sign_q ? −quo : quo.
  - hi_out = sign_r ? −rem[31:0] : rem[31:0].
  - Pulse `done`. Go to IDLE.
- **Semantics:**
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend, or is 0.
  - quotient×divisor + remainder == dividend (mod 2^32).
- **0x80000000 / 0xFFFFFFFF:** lo_out = 0x80000000, hi_out = 0. No overflow flag.
- **`start` while `busy`:** ignored. Operands are not re-sampled and the running division is unaffected.
- **`start` in the same cycle as `done`:** the state is already IDLE on the following edge, so a new `start` is accepted at that edge.

## Timing
- **Reset value of all outputs:** 0 (`busy`, `done`, `div_zero`, `hi_out`, `lo_out`). The reset state is IDLE.
- Let E0 be the rising edge at which `start` is sampled in IDLE.
- **Successful division:**
  - `busy` = 1 from after E0 until after E33.
  - CALC steps occur on E1..E32.
  - FIX is evaluated on E33: `hi_out`/`lo_out` update and `done` = 1 during the E33→E34 cycle.
  - Latency is 33 cycles from the start edge to `done`.
- **Divide by zero:** `div_zero` = 1 during the E0→E1 cycle only; `busy` stays 0.
- **Result hold:** `hi_out`/`lo_out` hold their value until the next FIX. They never show intermediate values.
- **`reset` asserted mid-operation:**
  - Immediately forces IDLE and zeroes all outputs and internal registers.
  - No `done` is produced for the aborted division.
  - After deassertion, the first accepted `start` behaves normally.
- **Control-unit contract:** the control unit holds its state until `done` or `div_zero` is seen. The pulse of either is never missed because both are registered one-cycle pulses.

## Test plan
- **7 / 2:**
  - `start` at E0 → `busy` high for 33 cycles.
  - `done` in cycle E33, with lo_out = 3 and hi_out = 1.
  - `done` high for exactly one cycle.
- **Sign combinations:**
  - −7/2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - 7/−2 → lo = 0xFFFFFFFD, hi = 1.
  - −7/−2 → lo = 3, hi = 0xFFFFFFFF.
- **Extremes:**
  - 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
  - 0xFFFFFFFF / 0x80000000 → lo = 0, hi = 0xFFFFFFFF.
  - 0 / 5 → lo = 0, hi = 0.
- **Divide by zero:**
  - After a completed 100/7, issue 5/0 → `div_zero` pulses one cycle at E0+1.
  - `busy`/`done` stay 0, and hi/lo remain 2/14.
- **`start` while busy:**
  - Issue 100/7, then at E10 `start` with 9/3 → only one `done`, at E33, with lo = 14 and hi = 2.
  - A second start issued in the `done` cycle with 9/3 → lo = 3, hi = 0 after 33 further cycles.
- **Reset mid-operation:**
  - Pulse `reset` low at E15 of 100/7 → all outputs read 0 immediately and no `done` appears.
  - A subsequent 20/6 yields lo = 3, hi = 2 with normal latency.

Source files
------------

// File: rtl/div_unit.sv
// Sequential signed restoring divider: quotient to LO, remainder to HI.
// One restoring step per cycle, 33-cycle latency from the start edge to done.
//
// state | meaning
// IDLE  | waiting for start; a zero divisor pulses div_zero and stays here
// CALC  | one restoring shift/subtract step per cycle, 32 steps
// FIX   | apply the operand signs, publish hi_out/lo_out, pulse done
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic [5:0]       cnt;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dsr;

  // quo starts out holding |dividend|, so shifting {rem, quo} feeds dividend bits MSB first.
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    trial   = rem_sh - {1'b0, dsr};
    abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    abs_dsr = divisor[WIDTH-1] ? -divisor : divisor;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              div_zero <= 1'b1;
            end else begin
              sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r <= dividend[WIDTH-1];
              quo    <= abs_dvd;
              dsr    <= abs_dsr;
              rem    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          lo_out <= sign_q ? -quo : quo;
          hi_out <= sign_r ? -rem : rem;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, multi-cycle corner
// sequences and random operands against a 64-bit arithmetic reference.
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int vectors = 0;
  int miscompares = 0;

  div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: truncating signed division done in 64 bits, so the
  // 0x80000000 / -1 case simply wraps back to 0x80000000.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = 32'(sa / sb);
    r = 32'(sa % sb);
  endfunction

  // Caller is at a negedge; returns 1 ns after the accepting edge E0.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Index 0 is the negedge inside E0->E1; done is expected at index 33.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: no done within 80 cycles");
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input bit timing);
    int lat, bc;
    @(negedge clock);
    issue(a, b);
    wait_done(lat, bc);
    check({tag, " lo"}, lo_out, exp_lo);
    check({tag, " hi"}, hi_out, exp_hi);
    if (timing) begin
      check({tag, " latency"}, 32'(lat), 32'd33);
      check({tag, " busy cycles"}, 32'(bc), 32'd33);
      @(negedge clock);
      check({tag, " done width"}, {31'd0, done}, 32'd0);
      check({tag, " busy after"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int lat, bc, ndone, done_at;
    logic [31:0] ra, rb, eq, er;

    tbl[0] = '{32'd7,        32'd2,        32'd3,        32'd1};
    tbl[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    tbl[2] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    tbl[3] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
    tbl[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    tbl[5] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF};
    tbl[6] = '{32'd0,        32'd5,        32'd0,        32'd0};
    tbl[7] = '{32'd20,       32'd6,        32'd3,        32'd2};
    tbl[8] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0};
    tbl[9] = '{32'd100,      32'd7,        32'd14,       32'd2};

    reset = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    check("reset hi", hi_out, 32'd0);
    check("reset lo", lo_out, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      run_div($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, (i == 0) || (i == 4));

    // Divide by zero after 100/7: one-cycle div_zero, results held.
    @(negedge clock);
    issue(32'd5, 32'd0);
    @(negedge clock);
    check("dz pulse", {31'd0, div_zero}, 32'd1);
    check("dz busy", {31'd0, busy}, 32'd0);
    check("dz done", {31'd0, done}, 32'd0);
    @(negedge clock);
    check("dz pulse end", {31'd0, div_zero}, 32'd0);
    check("dz busy later", {31'd0, busy}, 32'd0);
    check("dz hi hold", hi_out, 32'd2);
    check("dz lo hold", lo_out, 32'd14);

    // start while busy is ignored; then re-start in the done cycle.
    @(negedge clock);
    issue(32'd100, 32'd7);
    ndone = 0;
    done_at = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = i;
        if (ndone == 1) begin
          check("busy-start lo", lo_out, 32'd14);
          check("busy-start hi", hi_out, 32'd2);
          issue(32'd9, 32'd3);
          break;
        end
      end
      if (i == 9) begin
        start = 1'b1;
        dividend = 32'd9;
        divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    check("busy-start done index", 32'(done_at), 32'd33);
    wait_done(lat, bc);
    check("back-to-back lo", lo_out, 32'd3);
    check("back-to-back hi", hi_out, 32'd0);
    check("back-to-back latency", 32'(lat), 32'd33);

    // Reset mid-operation.
    @(negedge clock);
    issue(32'd100, 32'd7);
    repeat (15) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid-reset busy", {31'd0, busy}, 32'd0);
    check("mid-reset lo", lo_out, 32'd0);
    check("mid-reset hi", hi_out, 32'd0);
    check("mid-reset done", {31'd0, done}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("mid-reset no done", 32'(ndone), 32'd0);
    run_div("post-reset 20/6", 32'd20, 32'd6, 32'd3, 32'd2, 1'b1);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 1000);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (rb == 32'd0) rb = 32'd3;
      model(ra, rb, eq, er);
      run_div($sformatf("rnd%0d 0x%08h/0x%08h", i, ra, rb), ra, rb, eq, er, (i % 10) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
